pc_seq_ctrl: RTL and testbench

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

---
 rtl/pc_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer for the fetch stage: it handles boot, stalls on instruction memory,
// holds redirects that arrive during a stall, halts, and detects misaligned redirect targets.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  npc_op,
  input  logic        branch,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_instr,
  input  logic [31:0] rs_fwd,
  input  logic        load_use_stall,
  input  logic        halt_req,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        halted,
  output logic        addr_err
);

  typedef enum logic [1:0] {BOOT, FETCH, WAIT, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc_n, pend_tgt, pend_tgt_n;
  logic        pending, pending_n, halt_pend, halt_pend_n, addr_err_n;

  logic [31:0] br_target, j_target, target;
  logic        redir_valid, misalign, halt_now;

  assign br_target = id_pc + 32'd4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
  assign j_target  = {id_pc[31:28], id_instr[25:0], 2'b00};

  always_comb begin
    unique case (npc_op)
      2'b01:   target = br_target;
      2'b10:   target = j_target;
      2'b11:   target = rs_fwd;
      default: target = id_pc + 32'd4;
    endcase
  end

  assign redir_valid = ((npc_op == 2'b01 && branch) || npc_op[1]) && !load_use_stall;
  assign misalign    = redir_valid && (target[1:0] != 2'b00);
  assign halt_now    = halt_req && !load_use_stall;

  // NOTE: every output and next-state value gets a default first, so no path infers a latch.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    pending_n   = pending;
    pend_tgt_n  = pend_tgt;
    halt_pend_n = halt_pend;
    addr_err_n  = addr_err;
    imem_req    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b1;
    halted      = 1'b0;

    unique case (state)
      BOOT: state_n = FETCH;

      FETCH: begin
        imem_req   = 1'b1;
        ifid_write = 1'b1;
        if (halt_now) begin
          // Halt outranks any redirect; pc stays on the address of the fetch that ended the stream.
          if (imem_ready) state_n = HALT;
          else begin
            state_n     = WAIT;
            halt_pend_n = 1'b1;
          end
        end else if (misalign) begin
          addr_err_n = 1'b1;
          state_n    = HALT;
        end else if (!imem_ready) begin
          state_n = WAIT;
          if (redir_valid) begin
            pending_n  = 1'b1;
            pend_tgt_n = target;
          end
        end else if (load_use_stall) begin
          ifid_write = 1'b0;
          ifid_flush = 1'b0;
        end else if (redir_valid) begin
          pc_n = target;
        end else begin
          pc_n       = pc + 32'd4;
          ifid_flush = 1'b0;
        end
      end

      WAIT: begin
        imem_req   = 1'b1;
        ifid_write = 1'b1;
        if (halt_now || halt_pend) begin
          halt_pend_n = 1'b1;
          if (imem_ready) state_n = HALT;
        end else if (misalign) begin
          addr_err_n = 1'b1;
          state_n    = HALT;
        end else if (!imem_ready) begin
          if (redir_valid) begin
            pending_n  = 1'b1;
            pend_tgt_n = target;
          end
        end else begin
          state_n   = FETCH;
          pending_n = 1'b0;
          // A live redirect is newer than anything held in the pending register.
          if (redir_valid) pc_n = target;
          else begin
            if (pending) pc_n = pend_tgt;
            if (load_use_stall) begin
              ifid_write = 1'b0;
              ifid_flush = 1'b0;
            end else if (!pending) begin
              pc_n       = pc + 32'd4;
              ifid_flush = 1'b0;
            end
          end
        end
      end

      HALT: halted = 1'b1;

      default: state_n = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      pending   <= 1'b0;
      pend_tgt  <= '0;
      halt_pend <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      pending   <= pending_n;
      pend_tgt  <= pend_tgt_n;
      halt_pend <= halt_pend_n;
      addr_err  <= addr_err_n;
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed testbench for pc_seq_ctrl. Inputs change 1 ns after a rising edge, and
// outputs are sampled 1 ns later, well away from the next edge.
module tb_pc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  npc_op;
  logic        branch;
  logic [31:0] id_pc, id_instr, rs_fwd;
  logic        load_use_stall, halt_req, imem_ready;
  logic        imem_req, ifid_write, ifid_flush, halted, addr_err;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  pc_seq_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .npc_op(npc_op), .branch(branch), .id_pc(id_pc),
    .id_instr(id_instr), .rs_fwd(rs_fwd), .load_use_stall(load_use_stall),
    .halt_req(halt_req), .imem_ready(imem_ready), .imem_req(imem_req), .pc(pc),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .halted(halted), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic exp_req, input logic exp_wr, input logic exp_fl, input string tag);
    check({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, exp_req});
    check({tag, ".ifid_write"}, {31'd0, ifid_write}, {31'd0, exp_wr});
    check({tag, ".ifid_flush"}, {31'd0, ifid_flush}, {31'd0, exp_fl});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; npc_op = 2'b00; branch = 1'b0; id_pc = '0; id_instr = '0; rs_fwd = '0;
    load_use_stall = 1'b0; halt_req = 1'b0; imem_ready = 1'b1;
    tick();
    check("rst.pc", pc, 32'h3000);
    ctl(1'b0, 1'b0, 1'b1, "rst");
    check("rst.halted", {31'd0, halted}, 32'd0);
    check("rst.addr_err", {31'd0, addr_err}, 32'd0);
    tick();
    rst = 1'b0; #1;
    ctl(1'b0, 1'b0, 1'b1, "boot");

    // Sequential fetch
    tick(); check("seq.pc0", pc, 32'h3000); ctl(1'b1, 1'b1, 1'b0, "seq");
    tick(); check("seq.pc1", pc, 32'h3004);
    tick(); check("seq.pc2", pc, 32'h3008);

    // Taken branch, imm=3: 3004+4+12
    id_pc = 32'h3004; id_instr = 32'h1000_0003; npc_op = 2'b01; branch = 1'b1; #1;
    ctl(1'b1, 1'b1, 1'b1, "br_taken");
    tick(); check("br.pc", pc, 32'h3014);
    // Negative offset, imm=0xFFFF: 3004+4-4
    id_instr = 32'h1000_FFFF; #1;
    tick(); check("br_neg.pc", pc, 32'h3004);
    branch = 1'b0; #1;
    ctl(1'b1, 1'b1, 1'b0, "br_not_taken");
    tick(); check("br_nt.pc", pc, 32'h3008);
    npc_op = 2'b00;

    // Memory wait with j in the second wait cycle: target {0, C10, 00} = 3040
    imem_ready = 1'b0; #1;
    ctl(1'b1, 1'b1, 1'b1, "wait1");
    tick(); check("wait1.pc", pc, 32'h3008);
    npc_op = 2'b10; id_pc = 32'h3008; id_instr = 32'h0800_0C10;
    tick(); check("wait2.pc", pc, 32'h3008);
    npc_op = 2'b00;
    tick(); check("wait3.pc", pc, 32'h3008);
    imem_ready = 1'b1; #1;
    ctl(1'b1, 1'b1, 1'b1, "wait_done");
    tick(); check("wait.redir_pc", pc, 32'h3040);
    ctl(1'b1, 1'b1, 1'b0, "after_wait");

    // A live redirect in the ready cycle overrides an older pending target
    imem_ready = 1'b0; npc_op = 2'b11; rs_fwd = 32'h5000;
    tick(); check("pend_old.pc", pc, 32'h3040);
    imem_ready = 1'b1; rs_fwd = 32'h6000;
    tick(); check("live_wins.pc", pc, 32'h6000);
    npc_op = 2'b00;
    tick(); check("live_seq.pc", pc, 32'h6004);

    // Stall against jr
    load_use_stall = 1'b1; npc_op = 2'b11; rs_fwd = 32'h4000; #1;
    ctl(1'b1, 1'b0, 1'b0, "stall");
    tick(); check("stall.pc", pc, 32'h6004);
    load_use_stall = 1'b0;
    tick(); check("unstall.pc", pc, 32'h4000);
    npc_op = 2'b00;

    // Reset while a fetch is outstanding
    imem_ready = 1'b0;
    tick(); check("rwait.pc", pc, 32'h4000);
    rst = 1'b1; #1;
    check("rwait.rst_pc", pc, 32'h3000);
    ctl(1'b0, 1'b0, 1'b1, "rwait_rst");
    imem_ready = 1'b1;
    tick(); check("rwait.ready_pc", pc, 32'h3000);
    rst = 1'b0; #1;
    ctl(1'b0, 1'b0, 1'b1, "rwait_boot");
    tick(); check("rwait.fetch_pc", pc, 32'h3000);
    ctl(1'b1, 1'b1, 1'b0, "rwait_fetch");

    // halt_req beats a simultaneous jump
    halt_req = 1'b1; npc_op = 2'b10; id_pc = 32'h3008; id_instr = 32'h0800_0C10;
    tick();
    check("halt.halted", {31'd0, halted}, 32'd1);
    check("halt.pc", pc, 32'h3000);
    ctl(1'b0, 1'b0, 1'b1, "halt");
    halt_req = 1'b0; npc_op = 2'b00;
    tick();
    check("halt_hold.halted", {31'd0, halted}, 32'd1);
    check("halt_hold.pc", pc, 32'h3000);

    // Misaligned jr
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check("mis.pre_pc", pc, 32'h3000);
    npc_op = 2'b11; rs_fwd = 32'h3002;
    tick();
    check("mis.addr_err", {31'd0, addr_err}, 32'd1);
    check("mis.halted", {31'd0, halted}, 32'd1);
    check("mis.pc", pc, 32'h3000);
    ctl(1'b0, 1'b0, 1'b1, "mis");
    npc_op = 2'b00;
    tick();
    check("mis.sticky", {31'd0, addr_err}, 32'd1);
    check("mis.frozen_pc", pc, 32'h3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
